// File: rtl/seven_segment_arbiter.sv
// Round-robin arbiter that time-shares one seven-segment display between several requesters.
// The winner keeps the display for at least HOLD_CYCLES cycles while others wait.
module seven_segment_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned NUM_SEGMENTS = 8,
  parameter int unsigned HOLD_CYCLES  = 50_000_000
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ*NUM_SEGMENTS*4-1:0]   encoded_in,
  input  logic [NUM_REQ*NUM_SEGMENTS-1:0]     dp_in,
  output logic [NUM_REQ-1:0]                  gnt,
  output logic [$clog2(NUM_REQ)-1:0]          owner,
  output logic                                active,
  output logic [NUM_SEGMENTS*4-1:0]           encoded,
  output logic [NUM_SEGMENTS-1:0]             digit_point
);

  localparam int unsigned OwnerW = $clog2(NUM_REQ);
  localparam int unsigned CntW   = $clog2(HOLD_CYCLES);
  localparam int unsigned FrameW = NUM_SEGMENTS * 4;

  localparam logic [CntW-1:0]   CntMax   = CntW'(HOLD_CYCLES - 1);
  localparam logic [OwnerW-1:0] OwnerRst = OwnerW'(NUM_REQ - 1);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e                 state_q, state_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [OwnerW-1:0]      owner_q, owner_d;
  logic                   active_q, active_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [FrameW-1:0]      encoded_q;
  logic [NUM_SEGMENTS-1:0] dp_q;

  logic [OwnerW-1:0]       win_idx;
  logic [OwnerW-1:0]       cand;
  logic                    win_found;
  logic                    owner_req;
  logic                    others;
  logic [FrameW-1:0]       frame_sel;
  logic [NUM_SEGMENTS-1:0] dp_sel;

  // Search starts just after the current owner, so the owner itself is checked last.
  always_comb begin
    win_idx   = owner_q;
    win_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = OwnerW'((32'(owner_q) + k) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign owner_req = req[owner_q];
  assign others    = |(req & ~gnt_q);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d        = StHold;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          owner_d        = win_idx;
          active_d       = 1'b1;
          cnt_d          = '0;
        end
      end
      StHold: begin
        if (!owner_req) begin
          if (win_found) begin
            gnt_d          = '0;
            gnt_d[win_idx] = 1'b1;
            owner_d        = win_idx;
            cnt_d          = '0;
          end else begin
            state_d  = StIdle;
            gnt_d    = '0;
            active_d = 1'b0;
            cnt_d    = '0;
          end
        end else if ((cnt_q == CntMax) && others) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          owner_d        = win_idx;
          cnt_d          = '0;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      owner_q  <= OwnerRst;
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    frame_sel = '0;
    dp_sel    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == OwnerW'(i)) begin
        frame_sel = encoded_in[i*FrameW +: FrameW];
        dp_sel    = dp_in[i*NUM_SEGMENTS +: NUM_SEGMENTS];
      end
    end
  end

  // Frame follows the registered owner, so a new owner's data appears one edge after its grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      encoded_q <= '0;
      dp_q      <= '0;
    end else begin
      encoded_q <= active_q ? frame_sel : '0;
      dp_q      <= active_q ? dp_sel : '0;
    end
  end

  assign gnt         = gnt_q;
  assign owner       = owner_q;
  assign active      = active_q;
  assign encoded     = encoded_q;
  assign digit_point = dp_q;

endmodule

// File: doc/seven_segment_arbiter.md
# seven_segment_arbiter

Time-shares one multi-digit seven-segment display between several independent requesters (counters, status monitors, debug readouts). Each requester presents a full frame of hex digits and decimal points plus a request line; the arbiter grants one owner at a time, round-robin, with a guaranteed minimum display time. The selected frame is registered and fed to the `encoded` / `digit_point` inputs of the seven-segment driver.

## Interface
- `NUM_REQ`, 4: number of requesters (2..16).
- `NUM_SEGMENTS`, 8: digits per frame; must match the downstream display driver.
- `HOLD_CYCLES`, 50_000_000: minimum clock cycles an owner keeps the display while others wait (0.5 s at 100 MHz); must be ≥ 2.

- `clk`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `req`  in  NUM_REQ  per-requester request, level-sensitive.
- `encoded_in`  in  NUM_REQ×NUM_SEGMENTS×4  per-requester hex digit frame.
- `dp_in`  in  NUM_REQ×NUM_SEGMENTS  per-requester decimal points.
- `gnt`  out  NUM_REQ  one-hot grant; all zero when idle.
- `owner`  out  $clog2(NUM_REQ)  index of current or last owner.
- `active`  out  1  high while a grant is held.
- `encoded`  out  NUM_SEGMENTS×4  registered frame to the display driver.
- `digit_point`  out  NUM_SEGMENTS  registered decimal points to the display driver.

## Operation
- States: IDLE, HOLD.
- Reset values: IDLE, `gnt`=0, `active`=0, `owner`=NUM_REQ-1, `encoded`=0, `digit_point`=0, hold counter=0. With `owner` reset to NUM_REQ-1, requester 0 wins the first arbitration.
- Round-robin pick: search `req` from (`owner`+1) mod NUM_REQ upward with wrap. The first set bit wins, so the current owner has the lowest priority.
- **IDLE**
  - Any `req` bit set → pick winner, set `gnt`/`owner`, `active`=1, counter=0, go to HOLD.
- **HOLD**
  - Counter increments each cycle and saturates at HOLD_CYCLES-1.
  - Owner drops `req` at any time → release immediately.
    - Other requests pending: grant moves directly to the round-robin winner (no idle gap) and the counter clears.
    - None pending: go to IDLE with `gnt`=0 and `active`=0. `owner` keeps the last index.
  - Owner still requesting, counter == HOLD_CYCLES-1, and another `req` bit set → preempt. Grant rotates to the winner and the counter clears.
  - Owner still requesting with no competitors → keep the grant indefinitely; the counter stays saturated.
  - Competitor arrives after saturation → preempt on the next edge.
- Data path:
  - `encoded` ≤ `encoded_in[owner]` and `digit_point` ≤ `dp_in[owner]` every cycle while `active`.
  - When not active, both load 0: blank frame, display shows "00000000" with no points.
  - The owner's live frame updates propagate continuously (one register stage).
- Exactly one `gnt` bit is high whenever `active`=1. `gnt` never changes except at the transitions above.

## Timing
- `req` sampled at edge N in IDLE → `gnt`/`owner`/`active` valid after edge N; `encoded` shows the new owner's frame after edge N+1.
- Handover latency: owner drop at edge N → new `gnt` after edge N, new frame after edge N+1.
- Minimum grant length under contention: exactly HOLD_CYCLES cycles, measured from the `gnt` rising edge to the preempting edge.
- Simultaneous owner drop and hold expiry: treat as a drop; the result is identical.
- A new requester arriving on the same edge as a release is eligible in that arbitration.
- `reset_n` assertion mid-grant → all outputs go to reset values asynchronously. Deassertion is synchronised by the system; the first arbitration occurs on the first edge after it.
- Counter width: $clog2(HOLD_CYCLES); no wrap past HOLD_CYCLES-1.

## Test plan
Bench configuration: `NUM_REQ`=4, `HOLD_CYCLES`=4.

1. Reset → `gnt`=0000, `active`=0, `owner`=3, `encoded`=0. Then `req`=0001 at edge 1 → `gnt`=0001 after edge 1; `encoded`=`encoded_in[0]` after edge 2.
2. `req`=1111 held constant → grants 0001, 0010, 0100, 1000, 0001, … each exactly 4 cycles, no idle gaps.
3. Owner 2 holding, `req` drops to 1001 at hold cycle 1 → `gnt`=1000 on the next edge (early release, rotation from 2 to 3). Counter restarts at 0.
4. Single requester 1 held for 20 cycles → `gnt`=0010 throughout. `req`=0011 added at cycle 20 → `gnt`=0001 after the next edge.
5. Owner drops with no other requests → IDLE, `gnt`=0, `encoded`=0 one edge later. Next `req`=0101 → requester 2 wins, since 2 follows the last owner 1.
6. `reset_n` low for 3 ns mid-grant, between edges → outputs clear immediately without a clock edge. After release with `req`=0100 → `gnt`=0100.
